// File: rtl/issue_window_pkg.sv
// Shared types for the in-order issue window: decode fields, window entries and
// the pairwise register hazard check.
package issue_window_pkg;

    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic       is_valid;
        logic       is_branch;
        logic       is_mdu;
        logic       is_mem_access;
        logic       reg_write;
        logic [4:0] rs_addr;
        logic [4:0] rt_addr;
        logic [4:0] write_reg_addr;
    } PartialDecodeResult;

    typedef struct packed {
        PartialDecodeResult decode;
        logic [31:0]        pc;
    } IssueEntry;

    // a is the older instruction, b the younger; register 0 never conflicts
    function automatic logic regs_conflict(PartialDecodeResult a, PartialDecodeResult b);
        logic raw, waw, war;
        raw = a.reg_write && (a.write_reg_addr != 5'd0) &&
              ((a.write_reg_addr == b.rs_addr) || (a.write_reg_addr == b.rt_addr));
        waw = a.reg_write && b.reg_write && (a.write_reg_addr != 5'd0) &&
              (a.write_reg_addr == b.write_reg_addr);
        war = b.reg_write && (b.write_reg_addr != 5'd0) &&
              ((b.write_reg_addr == a.rs_addr) || (b.write_reg_addr == a.rt_addr));
        return raw | waw | war;
    endfunction

endpackage

// File: rtl/issue_window_scoreboard.sv
// Load-use scoreboard: one small down-counter per register, reloaded when a
// load issues to that register.
module issue_scoreboard
    import issue_window_pkg::*;
#(
    parameter int ISSUE_WIDTH  = 2,
    parameter int LOAD_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ISSUE_WIDTH-1:0]      set_valid,
    input  logic [ISSUE_WIDTH-1:0][4:0] set_addr,
    output logic [NUM_REGS-1:0]         busy
);

    logic [NUM_REGS-1:0][1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        busy  = '0;
        // register 0 is skipped so its counter stays zero forever
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != 2'd0);
            if (busy[r]) cnt_d[r] = cnt_q[r] - 2'd1;
            for (int k = 0; k < ISSUE_WIDTH; k++)
                if (set_valid[k] && (set_addr[k] == 5'(r))) cnt_d[r] = 2'(LOAD_LATENCY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/issue_window.sv
// In-order issue window between decode and register read: ring buffer plus
// oldest-first multi-issue selection with hazard and load-use checks.
module issue_window
    import issue_window_pkg::*;
#(
    parameter  int DEPTH        = 8,
    parameter  int FETCH_WIDTH  = 2,
    parameter  int ISSUE_WIDTH  = 2,
    parameter  int LOAD_LATENCY = 2,
    localparam int AW           = $clog2(DEPTH),
    localparam int CW           = AW + 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                single_issue,
    input  logic [FETCH_WIDTH-1:0]              in_valid,
    input  PartialDecodeResult [FETCH_WIDTH-1:0] in_decode,
    input  logic [FETCH_WIDTH-1:0][31:0]        in_pc,
    output logic                                in_ready,
    output logic [ISSUE_WIDTH-1:0]              out_valid,
    output PartialDecodeResult [ISSUE_WIDTH-1:0] out_decode,
    output logic [ISSUE_WIDTH-1:0][31:0]        out_pc,
    input  logic                                out_ready,
    output logic [CW-1:0]                       count
);

    IssueEntry [DEPTH-1:0]       mem_q, mem_d;
    logic [AW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic [CW-1:0]               push_n, pop_n;
    logic                        push_en;
    logic [NUM_REGS-1:0]         busy;
    logic [ISSUE_WIDTH-1:0]      set_valid;
    logic [ISSUE_WIDTH-1:0][4:0] set_addr;

    // space check uses registered count only, so same-cycle issues never help a push
    assign in_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));
    assign count    = count_q;

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            out_decode[k] = mem_q[head_q + AW'(k)].decode;
            out_pc[k]     = mem_q[head_q + AW'(k)].pc;
        end
    end

    always_comb begin
        logic ok, prev, serial, sb_ok;
        PartialDecodeResult d;
        out_valid = '0;
        prev      = 1'b1;
        serial    = 1'b0;
        ok        = 1'b0;
        sb_ok     = 1'b0;
        d         = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            d      = out_decode[k];
            sb_ok  = !busy[d.rs_addr] && !busy[d.rt_addr] &&
                     !(d.reg_write && busy[d.write_reg_addr]);
            ok     = prev && (k < int'(count_q)) && (k == 0 || !single_issue) && sb_ok;
            // any branch/MDU/memory op at or before slot k blocks slot k>0
            serial = serial | d.is_branch | d.is_mdu | d.is_mem_access;
            if (k > 0) begin
                ok = ok && !serial;
                for (int j = 0; j < k; j++)
                    if (regs_conflict(out_decode[j], d)) ok = 1'b0;
            end
            out_valid[k] = ok;
            prev         = ok;
        end
    end

    always_comb begin
        logic consume;
        pop_n     = '0;
        set_valid = '0;
        set_addr  = '0;
        consume   = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            consume      = out_valid[k] && out_ready && !flush;
            pop_n        = pop_n + CW'(consume);
            set_valid[k] = consume && out_decode[k].is_mem_access && out_decode[k].reg_write &&
                           (out_decode[k].write_reg_addr != 5'd0);
            set_addr[k]  = out_decode[k].write_reg_addr;
        end
    end

    always_comb begin
        push_en = in_ready && in_valid[0] && !flush;
        push_n  = '0;
        mem_d   = mem_q;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            if (push_en && in_valid[s]) begin
                push_n                    = push_n + CW'(1);
                mem_d[tail_q + AW'(s)] = '{decode: in_decode[s], pc: in_pc[s]};
            end
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + pop_n[AW-1:0];
            tail_d  = tail_q + push_n[AW-1:0];
            count_d = count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // entry payload needs no reset; count gates every read
    always_ff @(posedge clk) mem_q <= mem_d;

    issue_scoreboard #(
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .LOAD_LATENCY(LOAD_LATENCY)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_valid(set_valid),
        .set_addr (set_addr),
        .busy     (busy)
    );

endmodule

// File: tb/tb_issue_window.sv
// Directed bench for issue_window: expected issue PCs are queued at push time and
// popped as the window issues; group shapes and occupancy are checked per step.
module tb_issue_window;
    import issue_window_pkg::*;

    localparam int LL = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     flush = 1'b0;
    logic                     single_issue = 1'b0;
    logic [1:0]               in_valid = '0;
    PartialDecodeResult [1:0] in_decode = '0;
    logic [1:0][31:0]         in_pc = '0;
    logic                     in_ready;
    logic [1:0]               out_valid;
    PartialDecodeResult [1:0] out_decode;
    logic [1:0][31:0]         out_pc;
    logic                     out_ready = 1'b1;
    logic [3:0]               count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    issue_window #(.DEPTH(8), .FETCH_WIDTH(2), .ISSUE_WIDTH(2), .LOAD_LATENCY(LL)) dut (
        .clk(clk), .reset(reset), .flush(flush), .single_issue(single_issue),
        .in_valid(in_valid), .in_decode(in_decode), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_decode(out_decode), .out_pc(out_pc),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic PartialDecodeResult alu(int d, int s, int t);
        PartialDecodeResult r = '0;
        r.is_valid = 1'b1; r.reg_write = 1'b1;
        r.write_reg_addr = 5'(d); r.rs_addr = 5'(s); r.rt_addr = 5'(t);
        return r;
    endfunction

    function automatic PartialDecodeResult lw(int d, int base);
        PartialDecodeResult r = '0;
        r.is_valid = 1'b1; r.reg_write = 1'b1; r.is_mem_access = 1'b1;
        r.write_reg_addr = 5'(d); r.rs_addr = 5'(base); r.rt_addr = 5'(d);
        return r;
    endfunction

    function automatic PartialDecodeResult beq(int s, int t);
        PartialDecodeResult r = '0;
        r.is_valid = 1'b1; r.is_branch = 1'b1; r.rs_addr = 5'(s); r.rt_addr = 5'(t);
        return r;
    endfunction

    function automatic PartialDecodeResult mult(int s, int t);
        PartialDecodeResult r = '0;
        r.is_valid = 1'b1; r.is_mdu = 1'b1; r.rs_addr = 5'(s); r.rt_addr = 5'(t);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push2(input PartialDecodeResult d0, input logic [31:0] p0,
                         input PartialDecodeResult d1, input logic [31:0] p1, input bit enq);
        in_valid = 2'b11;
        in_decode[0] = d0; in_pc[0] = p0;
        in_decode[1] = d1; in_pc[1] = p1;
        if (enq) begin
            exp_q.push_back(p0);
            exp_q.push_back(p1);
        end
    endtask

    task automatic push1(input PartialDecodeResult d0, input logic [31:0] p0);
        in_valid = 2'b01;
        in_decode[0] = d0; in_pc[0] = p0;
        in_decode[1] = '0; in_pc[1] = '0;
        exp_q.push_back(p0);
    endtask

    // consumes one clock; anything issued this cycle is checked against the queue
    task automatic tick();
        #1;
        if (!reset && !flush && out_ready) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid[k]) begin
                    n_assert++;
                    assert (exp_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL issue_unexpected: observed pc %0h expected none", out_pc[k]);
                    end
                    if (exp_q.size() != 0) chk("issue_pc", out_pc[k], exp_q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        flush    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_count", 32'(count), 32'h0);

        // independent pair dual-issues
        push2(alu(1, 2, 3), 32'h100, alu(4, 5, 6), 32'h104, 1);
        tick();
        chk("dual_count", 32'(count), 32'h2);
        chk("dual_valid", 32'(out_valid), 32'h3);
        tick();
        chk("dual_drained", 32'(count), 32'h0);

        // RAW inside the group splits it
        push2(alu(1, 2, 3), 32'h110, alu(7, 1, 4), 32'h114, 1);
        tick();
        chk("raw_c1", 32'(out_valid), 32'h1);
        tick();
        chk("raw_c2", 32'(out_valid), 32'h1);
        chk("raw_c2_pc", out_pc[0], 32'h114);
        tick();

        // forced single issue on independent ops
        single_issue = 1'b1;
        push2(alu(1, 2, 3), 32'h120, alu(4, 5, 6), 32'h124, 1);
        tick();
        chk("single_c1", 32'(out_valid), 32'h1);
        tick();
        chk("single_c2", 32'(out_valid), 32'h1);
        tick();
        single_issue = 1'b0;

        // load-use stall for LL cycles
        push2(lw(8, 29), 32'h200, alu(9, 8, 0), 32'h204, 1);
        tick();
        chk("lu_lw", 32'(out_valid), 32'h1);
        tick();
        repeat (LL) begin
            chk("lu_stall", 32'(out_valid), 32'h0);
            tick();
        end
        chk("lu_release", 32'(out_valid), 32'h1);
        tick();
        push2(lw(0, 29), 32'h210, alu(9, 0, 0), 32'h214, 1);
        tick();
        chk("lw0_lw", 32'(out_valid), 32'h1);
        tick();
        chk("lw0_nostall", 32'(out_valid), 32'h1);
        tick();

        // fill to full with downstream stalled, then drain across the wrap
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            push2(alu(10 + 2 * g, 2, 3), 32'h300 + 32'(8 * g),
                  alu(11 + 2 * g, 2, 3), 32'h304 + 32'(8 * g), 1);
            tick();
        end
        chk("full_count", 32'(count), 32'h8);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        push2(alu(20, 2, 3), 32'h400, alu(21, 2, 3), 32'h404, 0);
        tick();
        chk("full_reject", 32'(count), 32'h8);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_count", 32'(count), 32'(8 - 2 * i));
            chk("drain_valid", 32'(out_valid), 32'h3);
            tick();
            if (i == 0) chk("drain_in_ready", 32'(in_ready), 32'h1);
        end
        chk("drain_empty", 32'(count), 32'h0);

        // branch/MDU/memory ops issue alone
        push2(beq(1, 2), 32'h500, alu(3, 4, 5), 32'h504, 1);
        tick();
        push2(mult(6, 7), 32'h508, lw(9, 29), 32'h50C, 1);
        chk("st_beq", 32'(out_valid), 32'h1);
        tick();
        chk("st_addu", 32'(out_valid), 32'h1);
        tick();
        chk("st_mult", 32'(out_valid), 32'h1);
        tick();
        chk("st_lw", 32'(out_valid), 32'h1);
        tick();
        chk("st_empty", 32'(count), 32'h0);

        // flush drops the push but keeps the in-flight load busy
        push1(lw(5, 29), 32'h600);
        tick();
        chk("fl_lw", 32'(out_valid), 32'h1);
        tick();
        flush = 1'b1;
        push2(alu(12, 2, 3), 32'h700, alu(13, 2, 3), 32'h704, 0);
        tick();
        chk("fl_count", 32'(count), 32'h0);
        chk("fl_valid", 32'(out_valid), 32'h0);
        push1(alu(6, 5, 0), 32'h610);
        tick();
        chk("fl_sb_stall", 32'(out_valid), 32'h0);
        tick();
        chk("fl_sb_release", 32'(out_valid), 32'h1);
        tick();

        // reset mid-stream clears the scoreboard too
        push1(lw(5, 29), 32'h620);
        tick();
        chk("rs_lw", 32'(out_valid), 32'h1);
        tick();
        reset = 1'b1;
        push2(alu(12, 2, 3), 32'h720, alu(13, 2, 3), 32'h724, 0);
        tick();
        reset = 1'b0;
        chk("rs_count", 32'(count), 32'h0);
        chk("rs_valid", 32'(out_valid), 32'h0);
        chk("rs_in_ready", 32'(in_ready), 32'h1);
        push1(alu(6, 5, 0), 32'h630);
        tick();
        chk("rs_sb_clear", 32'(out_valid), 32'h1);
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_window.md
Name: issue_window

Overview:
- Parametrised successor to the two-slot dual-issue check: a small in-order instruction window between decode and register read.
- Buffers FETCH_WIDTH partially-decoded instructions per cycle and issues up to ISSUE_WIDTH per cycle, oldest first.
- Applies intra-group RAW/WAW/WAR checks, the structural rules for branch/MDU/memory instructions, and a load-use scoreboard against in-flight loads.
- Adds flush and a forced single-issue mode.

Parameters:
- DEPTH, 8, window entries; power of two, >= FETCH_WIDTH.
- FETCH_WIDTH, 2, instructions offered per cycle; 1..4.
- ISSUE_WIDTH, 2, maximum instructions issued per cycle; 1..4.
- LOAD_LATENCY, 2, cycles a load's destination stays busy after issue; 1..3.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; synchronous, active-high.
- flush  input  1  discard all window entries.
- single_issue  input  1  when 1, behave as ISSUE_WIDTH=1.
- in_valid  input  FETCH_WIDTH  per-slot valid; slot 0 is oldest; valid bits are contiguous from slot 0.
- in_decode  input  FETCH_WIDTH x PartialDecodeResult  decoded instructions.
- in_pc  input  FETCH_WIDTH x 32  instruction PCs.
- in_ready  output  1  window accepts the whole in_valid group this cycle.
- out_valid  output  ISSUE_WIDTH  per-slot issue; contiguous from slot 0.
- out_decode  output  ISSUE_WIDTH x PartialDecodeResult  issued instructions.
- out_pc  output  ISSUE_WIDTH x 32  issued PCs.
- out_ready  input  1  downstream accepts the issue group; 0 means stall.
- count  output  log2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy.
- Reset: pointers 0, count 0, all scoreboard counters 0.
  - Outputs after reset: out_valid all 0, in_ready 1, count 0.
- Push handshake:
  - in_ready = (DEPTH - count >= FETCH_WIDTH), computed from registered count only.
  - Same-cycle issues do not free space for that cycle's push.
  - When in_ready & in_valid[0], all valid slots are written in slot order at tail; tail advances by popcount(in_valid).
  - A group is never partially accepted.
  - Slots with is_valid=0 in the decode struct are still stored.
- Pushed entries are visible at the head no earlier than the next cycle; there is no bypass from input to output.
- Issue candidates: entry head+k for k < min(ISSUE_WIDTH, count), or only k=0 when single_issue=1.
- Slot 0 issues iff all of:
  - the entry exists;
  - neither its rs_addr nor its rt_addr is busy in the scoreboard;
  - if reg_write, its write_reg_addr is not busy.
- Slot k>0 issues iff all of:
  - slot k-1 issues;
  - slot k passes the same scoreboard check;
  - no RAW, WAW or WAR against any slot j<k (same rules as the dual-issue check, register 0 ignored);
  - neither slot k nor any slot j<k has is_branch, is_mdu or is_mem_access set.
- Consequence: branch/MDU/memory instructions issue only as slot 0, alone.
- Combinational outputs: out_valid is derived from current state; out_decode/out_pc present the head entries.
- When out_ready=1, head advances by popcount(out_valid) and the scoreboard is updated. When out_ready=0, nothing is consumed and the scoreboard only counts down.
- Scoreboard: one counter of 2 bits per register (32 registers).
  - An issued instruction with is_mem_access & reg_write & write_reg_addr!=0 loads its destination counter with LOAD_LATENCY.
  - Every other nonzero counter decrements by 1 each cycle.
  - A register is busy while its counter is nonzero.
  - Register 0 is never busy.
  - A load and a decrement on the same register in the same cycle: the load wins.
- Flush:
  - Next cycle head=tail=0 and count=0.
  - Any push that cycle is dropped and no issue is consumed; out_valid is still driven, but downstream ignores it under flush.
  - The scoreboard is NOT cleared, because older loads remain in flight.
- Reset asserted mid-operation overrides flush, push and issue in the same cycle.
- count after each clock = count + pushed - issued, clamped by construction to 0..DEPTH.

Decomposition:
- Shared package (extends MipsDefinitions):
  - IssueEntry struct {PartialDecodeResult decode; logic [31:0] pc};
  - function regs_conflict(a, b), returning the RAW|WAW|WAR result for an ordered pair;
  - constant NUM_REGS=32.
- One sub-module, issue_scoreboard: per-register busy counters.
  - Inputs: set_valid, set_addr (ISSUE_WIDTH ports).
  - Output: busy[31:0].
- issue_window holds the ring buffer and the slot-select logic.

Test Plan:
- Dual-issue, DEPTH=8: push "addu $1,$2,$3 ; addu $4,$5,$6", out_ready=1 -> next cycle out_valid=2'b11, PCs 0x100/0x104, count goes 2->0.
- RAW in group: push "addu $1,$2,$3 ; subu $7,$1,$4" -> cycle 1 out_valid=2'b01, cycle 2 slot 0 = subu; same result with single_issue=1 for independent ops.
- Load-use, LOAD_LATENCY=2: issue lw $8 at cycle t; addu $9,$8,$0 at head -> out_valid=0 at t+1 and t+2, issues at t+3; a lw to $0 never stalls.
- Full/wrap: hold out_ready=0 and push 4 groups -> count=8, in_ready=0, the 5th group is not accepted; release out_ready -> 8 entries drain in PC order across the pointer wrap, in_ready returns to 1 when count<=6.
- Structural: push "beq ; addu" then "mult ; lw" -> issue groups {beq}, {addu}, {mult}, {lw}, each out_valid=2'b01.
- Flush with in-flight load: issue lw $5, assert flush with a push in the same cycle -> count=0 and the push is dropped; a new addu $6,$5,$0 still stalls until the $5 counter expires. Reset mid-stream -> count=0, out_valid=0, $5 no longer busy.
